pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline stage register with valid/ready handshake and a two-entry skid buffer. Replaces fixed-field EN/CLR stage registers between IF/ID/EX/MEM/WB: the payload is one WIDTH-bit bus packing data fields and control signals. The stage sustains one beat per cycle, breaks the combinational ready path between stages, and supports a flush that leaves an all-zero bubble, which decodes as a NOP. Optional performance counters report stall and bubble cycles.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- CNT_W, 32: width of each performance counter (≥1).

- clk  in  1  clock; all state updates on posedge.
- CLR  in  1  synchronous, active-high reset; clears everything, including the counters.
- flush  in  1  synchronous kill of held entries; counters are kept.
- in_valid  in  1  upstream beat offered.
- in_ready  out  1  stage accepts a beat; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload; registered.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1.

## Operation
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage: a main register (drives out_*) and a skid register.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions:
  - EMPTY + in_fire → ONE; main ← in_data.
  - ONE + in_fire + out_fire → ONE; main ← in_data.
  - ONE + in_fire only → FULL; skid ← in_data.
  - ONE + out_fire only → EMPTY.
  - FULL + out_fire → ONE; main ← skid.
  - FULL: no in_fire is possible.
- Outputs:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - occupancy follows the state encoding.
- Flush:
  - Next state is EMPTY. Main data and skid data are zeroed.
  - A beat accepted in the flush cycle is dropped.
  - An out_fire in the flush cycle counts as delivered.
- CLR has priority over flush. CLR does the same as flush and also zeroes both counters.
- Counters (macro on):
  - Evaluated every cycle that is not a CLR cycle.
  - Saturate at all-ones; no wrap.
- When out_valid=0, out_data holds its last value (zero after CLR or flush).

## Timing
- Reset values after CLR:
  - in_ready=1, out_valid=0, out_data=0, occupancy=0.
  - stall_cnt=0, bubble_cnt=0.
- Latency: a beat accepted at edge N is on out_data with out_valid=1 after edge N, in cycle N+1.
- Throughput: 1 beat/cycle while out_ready stays high.
- No combinational path from any input to any output. in_ready depends only on state.
- Back-pressure: out_ready low for one cycle while upstream streams leads to FULL. in_ready drops the following cycle, and exactly one beat is held in skid; no loss.
- Order is preserved: main is always the older beat, skid the younger.

## Configuration
- PIPE_SKID_PERF_EN:
  - Defined: stall_cnt and bubble_cnt are live saturating counters.
  - Undefined: both ports are tied to 0 and no counter flops are built.
  - Handshake behaviour is identical either way.

## Structure
- Shared package pipe_pkg:
  - State typedef with ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Default WIDTH/CNT_W constants.
  - Per-stage payload WIDTH constants for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sub-module pipe_sat_cnt:
  - CNT_W-wide saturating counter with sync clear and inc enable.
  - Instantiated twice under PIPE_SKID_PERF_EN.

## Test plan
- Stream: out_ready=1, in_valid=1 with data 1,2,3,4 → out_data 1,2,3,4 one cycle later each; in_ready stays 1; occupancy 1.
- Stall: in_data 0xA, 0xB accepted, out_ready=0 for 3 cycles → occupancy 2 and in_ready=0; out_ready=1 → outputs 0xA then 0xB; stall_cnt=3.
- Flush at FULL: hold 0x11, 0x22, pulse flush with in_valid=1 and in_data 0x33 → next cycle out_valid=0, out_data=0, occupancy 0; 0x33 never appears.
- CLR over flush: CLR and flush both high with counters nonzero → all reset values, counters 0.
- Saturation with CNT_W=2 and macro on: out_ready=1, in_valid=0 for 5 cycles → bubble_cnt reads 3 and stays at 3.
- Macro off: the stall scenario gives identical data and handshake; stall_cnt=bubble_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: state codes, default widths and per-stage payload widths.
package pipe_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_EMPTY = 2'd0;
   localparam state_t ST_ONE   = 2'd1;
   localparam state_t ST_FULL  = 2'd2;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_CNT_W = 32;

   // Payload widths of the inter-stage buses (data fields plus packed control bits).
   localparam int unsigned IF_ID_W  = 64;
   localparam int unsigned ID_EX_W  = 160;
   localparam int unsigned EX_MEM_W = 112;
   localparam int unsigned MEM_WB_W = 72;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module pipe_sat_cnt #(
   parameter int unsigned CNT_W = pipe_pkg::DEF_CNT_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a two-entry skid buffer and flush-to-bubble.
// Build option PIPE_SKID_PERF_EN enables the stall/bubble saturating counters.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   state_t           state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_fire;
   logic             out_fire;

   // Handshake outputs come straight from the state flops, so ready never ripples between stages.
   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (CLR || flush) begin
         state  <= ST_EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_q <= in_data;
                  state  <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data;
               end else if (in_fire) begin
                  skid_q <= in_data;
                  state  <= ST_FULL;
               end else if (out_fire) begin
                  state  <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_q <= skid_q;
                  state  <= ST_ONE;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

`ifdef PIPE_SKID_PERF_EN
   pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (CLR),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .clr   (CLR),
      .inc   (~out_valid & out_ready),
      .count (bubble_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a random run against a queue model.
module tb_pipe_skid_stage;

`ifdef PIPE_SKID_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam int unsigned W    = 32;
   localparam int unsigned CW   = 32;
   localparam int unsigned CW2  = 2;

   logic          clk = 1'b0;
   logic          CLR = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid;
   logic [W-1:0]  out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt, bubble_cnt;

   logic          in_ready2, out_valid2;
   logic [W-1:0]  out_data2;
   logic [1:0]    occupancy2;
   logic [CW2-1:0] stall_cnt2, bubble_cnt2;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: FIFO of held beats, last value shown on out_data, raw counts since CLR.
   logic [W-1:0] mq[$];
   logic [W-1:0] mlast = '0;
   longint       mstall = 0;
   longint       mbubble = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .CLR(CLR), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_skid_stage #(.WIDTH(W), .CNT_W(CW2)) dut2 (
      .clk(clk), .CLR(CLR), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .occupancy(occupancy2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
   );

   function automatic longint exp_cnt(input longint raw, input int unsigned w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      if (!PERF) return 0;
      return (raw > mx) ? mx : raw;
   endfunction

   // Advance the model with the inputs currently applied, then one clock edge.
   task automatic tick();
      bit m_rdy, m_vld, ifire, ofire;
      m_rdy = (mq.size() < 2);
      m_vld = (mq.size() > 0);
      ifire = in_valid && m_rdy;
      ofire = m_vld && out_ready;
      if (CLR) begin
         mq.delete();
         mlast   = '0;
         mstall  = 0;
         mbubble = 0;
      end else begin
         if (m_vld && !out_ready) mstall++;
         if (!m_vld && out_ready) mbubble++;
         if (flush) begin
            mq.delete();
            mlast = '0;
         end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
            if (mq.size() > 0) mlast = mq[0];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      CLR = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick();
      CLR = 1'b0;
   endtask

   task automatic test_reset();
      CLR = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD_BEEF;
      tick();
      CLR = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, occupancy, out_data} !== {1'b1, 1'b0, 2'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL reset_hs: got rdy=%0b vld=%0b occ=%0d data=%h want 1 0 0 0",
                  in_ready, out_valid, occupancy, out_data);
      end
      n_cmp++;
      if ({stall_cnt, bubble_cnt} !== 64'd0) begin
         n_bad++;
         $display("FAIL reset_cnt: got stall=%0d bubble=%0d want 0 0", stall_cnt, bubble_cnt);
      end
   endtask

   task automatic test_stream();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         in_data = W'(k);
         tick();
         n_cmp++;
         if ({in_ready, out_valid, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, W'(k)}) begin
            n_bad++;
            $display("FAIL stream_%0d: got rdy=%0b vld=%0b occ=%0d data=%h want 1 1 1 %h",
                     k, in_ready, out_valid, occupancy, out_data, k);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 32'hA; tick();
      in_data   = 32'hB; tick();
      in_valid  = 1'b0; in_data = 32'hC;
      tick(); tick();
      n_cmp++;
      if ({in_ready, out_valid, occupancy, out_data} !== {1'b0, 1'b1, 2'd2, 32'hA}) begin
         n_bad++;
         $display("FAIL stall_full: got rdy=%0b vld=%0b occ=%0d data=%h want 0 1 2 0000000a",
                  in_ready, out_valid, occupancy, out_data);
      end
      n_cmp++;
      if (64'(stall_cnt) !== exp_cnt(3, CW)) begin
         n_bad++;
         $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_cnt(3, CW));
      end
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if ({in_ready, out_valid, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, 32'hB}) begin
         n_bad++;
         $display("FAIL stall_drain1: got rdy=%0b vld=%0b occ=%0d data=%h want 1 1 1 0000000b",
                  in_ready, out_valid, occupancy, out_data);
      end
      tick();
      n_cmp++;
      if ({in_ready, out_valid, occupancy, out_data} !== {1'b1, 1'b0, 2'd0, 32'hB}) begin
         n_bad++;
         $display("FAIL stall_drain2: got rdy=%0b vld=%0b occ=%0d data=%h want 1 0 0 0000000b",
                  in_ready, out_valid, occupancy, out_data);
      end
      n_cmp++;
      if ({64'(stall_cnt), 64'(bubble_cnt)} !== {exp_cnt(3, CW), exp_cnt(0, CW)}) begin
         n_bad++;
         $display("FAIL stall_cnt_end: got stall=%0d bubble=%0d want %0d %0d",
                  stall_cnt, bubble_cnt, exp_cnt(3, CW), exp_cnt(0, CW));
      end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 32'h11; tick();
      in_data   = 32'h22; tick();
      flush = 1'b1; in_data = 32'h33;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, occupancy, out_data} !== {1'b1, 1'b0, 2'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL flush_full: got rdy=%0b vld=%0b occ=%0d data=%h want 1 0 0 0",
                  in_ready, out_valid, occupancy, out_data);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if ({out_valid, out_data} !== {1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL flush_after_%0d: got vld=%0b data=%h want 0 0", k, out_valid, out_data);
         end
      end
   endtask

   task automatic test_clr_over_flush();
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
      tick(); tick(); tick();
      n_cmp++;
      if (64'(stall_cnt) !== exp_cnt(2, CW)) begin
         n_bad++;
         $display("FAIL clr_pre_cnt: got %0d want %0d", stall_cnt, exp_cnt(2, CW));
      end
      CLR = 1'b1; flush = 1'b1; in_data = 32'h66;
      tick();
      CLR = 1'b0; flush = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, occupancy, out_data, stall_cnt, bubble_cnt} !==
          {1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL clr_over_flush: got rdy=%0b vld=%0b occ=%0d data=%h stall=%0d bubble=%0d want 1 0 0 0 0 0",
                  in_ready, out_valid, occupancy, out_data, stall_cnt, bubble_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b1; in_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         n_cmp++;
         if (64'(bubble_cnt2) !== exp_cnt(k, CW2)) begin
            n_bad++;
            $display("FAIL sat_bubble_%0d: got %0d want %0d", k, bubble_cnt2, exp_cnt(k, CW2));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         CLR       = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 49) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         tick();
         n_cmp++;
         if ({in_ready, out_valid, occupancy, out_data} !==
             {(mq.size() < 2), (mq.size() > 0), 2'(mq.size()), mlast}) begin
            n_bad++;
            $display("FAIL rand_hs_%0d: got rdy=%0b vld=%0b occ=%0d data=%h want %0b %0b %0d %h",
                     i, in_ready, out_valid, occupancy, out_data,
                     (mq.size() < 2), (mq.size() > 0), mq.size(), mlast);
         end
         n_cmp++;
         if ({64'(stall_cnt), 64'(bubble_cnt), 64'(stall_cnt2), 64'(bubble_cnt2)} !==
             {exp_cnt(mstall, CW), exp_cnt(mbubble, CW), exp_cnt(mstall, CW2), exp_cnt(mbubble, CW2)}) begin
            n_bad++;
            $display("FAIL rand_cnt_%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                     stall_cnt, bubble_cnt, stall_cnt2, bubble_cnt2,
                     exp_cnt(mstall, CW), exp_cnt(mbubble, CW), exp_cnt(mstall, CW2), exp_cnt(mbubble, CW2));
         end
      end
      CLR = 1'b0; flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_clr_over_flush();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
